// File: rtl/relm_ftoi_if.sv
// relm_ftoi_if: valid/ready stream bundle between firmware master and float-to-int converter
interface relm_ftoi_if #(parameter int WD = 32);
  logic          in_valid;
  logic          in_ready;
  logic [WD-1:0] in_data;
  logic [1:0]    in_mode;
  logic          out_valid;
  logic          out_ready;
  logic [WD-1:0] out_data;
  logic [2:0]    out_flags;
  modport master (output in_valid, in_data, in_mode, out_ready, input in_ready, out_valid, out_data, out_flags);
  modport slave (input in_valid, in_data, in_mode, out_ready, output in_ready, out_valid, out_data, out_flags);
endinterface

// File: rtl/relm_ftoi_seq.sv
// relm_ftoi_seq: multi-cycle float32 to int32 converter using an iterative 16/4/1 right-shifter
module relm_ftoi_seq #(parameter int WD = 32) (
  input logic clk,
  input logic rst_n,
  relm_ftoi_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, SHIFT = 2'd1, ROUND = 2'd2, DONE = 2'd3;
  logic [1:0]    state, mode;
  logic          s, st;
  logic [32:0]   x;
  logic [5:0]    r;
  logic [WD-1:0] data;
  logic [2:0]    flags;
  logic          sin, nan, spec, g, l, inc, lost;
  logic [7:0]    e;
  logic [22:0]   m;
  logic [8:0]    d9;
  logic [5:0]    k;
  logic [32:0]   xs;
  logic [31:0]   mag, res, sdata;
  logic [2:0]    sflags;
  // decode the incoming word, pick the shift step and form the rounded result
  always_comb begin
    sin = bus.in_data[31];
    e = bus.in_data[30:23];
    m = bus.in_data[22:0];
    nan = (e == 8'd255) && (m != 23'd0);
    spec = (e == 8'd0) || (e >= 8'd158);
    d9 = 9'd158 - {1'b0, e};
    sdata = (e == 8'd0 || nan) ? 32'd0 : sin ? 32'h8000_0000 : 32'h7FFF_FFFF;
    sflags = e == 8'd0 ? 3'b000 : nan ? 3'b100 : (sin && e == 8'd158 && m == 23'd0) ? 3'b000 : 3'b010;
    k = r >= 6'd16 ? 6'd16 : r >= 6'd4 ? 6'd4 : 6'd1;
    xs = r >= 6'd16 ? x >> 16 : r >= 6'd4 ? x >> 4 : x >> 1;
    lost = r >= 6'd16 ? |x[15:0] : r >= 6'd4 ? |x[3:0] : x[0];
    g = x[0];
    l = x[1];
    inc = mode == 2'd0 ? 1'b0 : mode == 2'd1 ? g & (st | l) : mode == 2'd2 ? s & (g | st) : ~s & (g | st);
    mag = x[32:1] + {31'd0, inc};
    res = s ? -mag : mag;
  end
  // converter FSM: accept/classify, shift down to integer, round, hold result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      mode <= 2'd0;
      s <= 1'b0;
      st <= 1'b0;
      x <= '0;
      r <= '0;
      data <= '0;
      flags <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          s <= sin;
          mode <= bus.in_mode;
          if (spec) begin
            data <= sdata;
            flags <= sflags;
            state <= DONE;
          end else begin
            x <= {1'b1, m, 9'd0};
            st <= 1'b0;
            r <= d9 > 9'd33 ? 6'd33 : d9[5:0];
            state <= SHIFT;
          end
        end
        SHIFT: begin
          x <= xs;
          st <= st | lost;
          r <= r - k;
          if (r == k) state <= ROUND;
        end
        ROUND: begin
          data <= res;
          flags <= {2'b00, g | st};
          state <= DONE;
        end
        default: if (bus.out_ready) state <= IDLE;
      endcase
    end
  end
  assign bus.in_ready = state == IDLE;
  assign bus.out_valid = state == DONE;
  assign bus.out_data = data;
  assign bus.out_flags = flags;
endmodule

// File: tb/tb_relm_ftoi_seq.sv
// tb_relm_ftoi_seq: table-driven directed checks of the float32 to int32 converter
module tb_relm_ftoi_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;
  relm_ftoi_if #(.WD(32)) bus();
  relm_ftoi_seq #(.WD(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] f;
    logic [1:0]  md;
    logic [31:0] d;
    logic [2:0]  fl;
    int          lat;
  } vec_t;
  vec_t v[19];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  // lat counts edges from the accept edge (inclusive) to the edge that raises out_valid
  task automatic conv(input logic [31:0] f, input logic [1:0] md, output logic [31:0] d, output logic [2:0] fl, output int lat);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data = f;
    bus.in_mode = md;
    @(posedge clk);
    lat = 1;
    #1;
    bus.in_valid = 1'b0;
    bus.in_data = 32'hDEAD_BEEF;
    bus.in_mode = 2'd3;
    while (!bus.out_valid && lat < 60) begin
      @(posedge clk);
      lat++;
      #1;
    end
    if (!bus.out_valid) chk("timeout out_valid", {31'd0, bus.out_valid}, 32'd1);
    d = bus.out_data;
    fl = bus.out_flags;
  endtask
  task automatic pop();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask
  initial begin
    logic [31:0] d;
    logic [2:0] fl;
    int lat;
    v[0]  = '{32'h3F80_0000, 2'd0, 32'd1,         3'b000, 9};
    v[1]  = '{32'h4049_0FDB, 2'd0, 32'd3,         3'b001, 8};
    v[2]  = '{32'h4049_0FDB, 2'd1, 32'd3,         3'b001, 8};
    v[3]  = '{32'h4049_0FDB, 2'd2, 32'd3,         3'b001, 8};
    v[4]  = '{32'h4049_0FDB, 2'd3, 32'd4,         3'b001, 8};
    v[5]  = '{32'hC020_0000, 2'd0, 32'hFFFF_FFFE, 3'b001, 8};
    v[6]  = '{32'hC020_0000, 2'd1, 32'hFFFF_FFFE, 3'b001, 8};
    v[7]  = '{32'hC020_0000, 2'd2, 32'hFFFF_FFFD, 3'b001, 8};
    v[8]  = '{32'hC020_0000, 2'd3, 32'hFFFF_FFFE, 3'b001, 8};
    v[9]  = '{32'h3F00_0000, 2'd1, 32'd0,         3'b001, 4};
    v[10] = '{32'h3F00_0000, 2'd3, 32'd1,         3'b001, 4};
    v[11] = '{32'h3FC0_0000, 2'd1, 32'd2,         3'b001, 9};
    v[12] = '{32'hBF00_0000, 2'd2, 32'hFFFF_FFFF, 3'b001, 4};
    v[13] = '{32'hBF00_0000, 2'd0, 32'd0,         3'b001, 4};
    v[14] = '{32'h4F00_0000, 2'd0, 32'h7FFF_FFFF, 3'b010, 1};
    v[15] = '{32'hCF00_0000, 2'd0, 32'h8000_0000, 3'b000, 1};
    v[16] = '{32'h7FC0_0000, 2'd0, 32'd0,         3'b100, 1};
    v[17] = '{32'hFF80_0000, 2'd0, 32'h8000_0000, 3'b010, 1};
    v[18] = '{32'h0040_0000, 2'd0, 32'd0,         3'b000, 1};
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_mode = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("reset in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("reset out_data", bus.out_data, 32'd0);
    chk("reset out_flags", {29'd0, bus.out_flags}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    foreach (v[i]) begin
      conv(v[i].f, v[i].md, d, fl, lat);
      chk($sformatf("vec%0d data", i), d, v[i].d);
      chk($sformatf("vec%0d flags", i), {29'd0, fl}, {29'd0, v[i].fl});
      chk($sformatf("vec%0d latency", i), lat, v[i].lat);
      pop();
      chk($sformatf("vec%0d idle after pop", i), {31'd0, bus.in_ready}, 32'd1);
    end
    conv(32'h4049_0FDB, 2'd3, d, fl, lat);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk("hold out_data", bus.out_data, 32'd4);
      chk("hold out_flags", {29'd0, bus.out_flags}, 32'd1);
      chk("hold in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("hold out_valid", {31'd0, bus.out_valid}, 32'd1);
    end
    pop();
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data = 32'h3F80_0000;
    bus.in_mode = 2'd0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("mid shift busy", {31'd0, bus.in_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("async reset out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("async reset out_data", bus.out_data, 32'd0);
    chk("async reset out_flags", {29'd0, bus.out_flags}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("post reset in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("post reset no stale result", {31'd0, bus.out_valid}, 32'd0);
    conv(32'h4120_0000, 2'd0, d, fl, lat);
    chk("ten data", d, 32'd10);
    chk("ten flags", {29'd0, fl}, 32'd0);
    chk("ten latency", lat, 6);
    pop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
